pong_game_state: RTL and testbench

//  Per-frame game engine for the Pong design: owns paddle, ball and score state.

---
 rtl/pong_pkg.sv | 50 +++++
 rtl/pong_paddle.sv | 31 +++
 rtl/pong_game_state.sv | 203 ++++++++++++++++++++
 tb/tb_pong_game_state.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared geometry, timing constants and state encodings for the Pong game engine.
package pong_pkg;

   localparam logic [9:0] H_RES        = 10'd640;
   localparam logic [9:0] V_RES        = 10'd480;
   localparam logic [9:0] PADDLE_H     = 10'd64;
   localparam logic [9:0] PADDLE_W     = 10'd8;
   localparam logic [9:0] BALL_SZ      = 10'd8;
   localparam logic [9:0] PADDLE_XL    = 10'd16;
   localparam logic [9:0] PADDLE_XR    = 10'd616;
   localparam logic [9:0] PADDLE_STEP  = 10'd4;
   localparam logic [9:0] BALL_STEP    = 10'd2;
   localparam logic [3:0] SCORE_MAX    = 4'd9;
   localparam logic [5:0] POINT_FRAMES = 6'd60;

   // Derived limits and centre positions
   localparam logic [9:0] BALL_X_MAX   = H_RES - BALL_SZ;         // 632
   localparam logic [9:0] BALL_Y_MAX   = V_RES - BALL_SZ;         // 472
   localparam logic [9:0] PADDLE_Y_MAX = V_RES - PADDLE_H;        // 416
   localparam logic [9:0] BALL_X0      = BALL_X_MAX >> 1;         // 316
   localparam logic [9:0] BALL_Y0      = BALL_Y_MAX >> 1;         // 236
   localparam logic [9:0] PADDLE_Y0    = PADDLE_Y_MAX >> 1;       // 208
   localparam logic [9:0] HIT_XL       = PADDLE_XL + PADDLE_W;    // 24
   localparam logic [9:0] HIT_XR       = PADDLE_XR - BALL_SZ;     // 608

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      STG_IDLE    = 2'd0,
      STG_PADDLE  = 2'd1,
      STG_BALL    = 2'd2,
      STG_RESOLVE = 2'd3
   } stage_t;

   // Ball and paddle share at least one row
   function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
      return ((by + BALL_SZ) > py) && (by < (py + PADDLE_H));
   endfunction

   // Score increment that holds at SCORE_MAX
   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= SCORE_MAX) ? s : s + 4'd1;
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: vertical position register with clamped up/down stepping.
module pong_paddle
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       step_en,
   input  logic       load,
   input  logic       up,
   input  logic       dn,
   output logic [9:0] pos
);

   // Position update: recentre on load, otherwise one clamped step when exactly one button is held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos <= PADDLE_Y0;
      end else if (ena) begin
         if (load) begin
            pos <= PADDLE_Y0;
         end else if (step_en && (up != dn)) begin
            if (up)
               pos <= (pos < PADDLE_STEP) ? '0 : pos - PADDLE_STEP;
            else
               pos <= (pos > (PADDLE_Y_MAX - PADDLE_STEP)) ? PADDLE_Y_MAX : pos + PADDLE_STEP;
         end
      end
   end

endmodule

// File: rtl/pong_game_state.sv
// Per-frame Pong engine: a three-stage update (paddles, ball, resolve) launched
// by frame_tick, plus the SERVE/PLAY/POINT/OVER game state machine.
module pong_game_state
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       frame_tick,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   input  logic       serve,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] paddle_l_y,
   output logic [9:0] paddle_r_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [1:0] game_state,
   output logic       update_done
);

   stage_t      stage, stage_nx;
   game_state_t state, state_nx;
   logic [9:0]  ball_x_nx, ball_y_nx;
   logic        vx, vy, vx_nx, vy_nx;          // 1 = moving toward larger coordinate
   logic [3:0]  score_l_nx, score_r_nx;
   logic [5:0]  pcnt, pcnt_nx;
   logic        serve_q, serve_q_nx;           // serve level captured with the tick
   logic        done_nx;
   logic        paddle_step, paddle_load;
   logic        hit_l, hit_r;

   assign game_state = state;

   pong_paddle u_paddle_l (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .step_en (paddle_step),
      .load    (paddle_load),
      .up      (btn_l_up),
      .dn      (btn_l_dn),
      .pos     (paddle_l_y)
   );

   pong_paddle u_paddle_r (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .step_en (paddle_step),
      .load    (paddle_load),
      .up      (btn_r_up),
      .dn      (btn_r_dn),
      .pos     (paddle_r_y)
   );

   // State register for pipeline stage, game FSM, ball and scores
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage       <= STG_IDLE;
         state       <= ST_SERVE;
         ball_x      <= BALL_X0;
         ball_y      <= BALL_Y0;
         vx          <= 1'b1;
         vy          <= 1'b1;
         score_l     <= '0;
         score_r     <= '0;
         pcnt        <= '0;
         serve_q     <= 1'b0;
         update_done <= 1'b0;
      end else if (ena) begin
         stage       <= stage_nx;
         state       <= state_nx;
         ball_x      <= ball_x_nx;
         ball_y      <= ball_y_nx;
         vx          <= vx_nx;
         vy          <= vy_nx;
         score_l     <= score_l_nx;
         score_r     <= score_r_nx;
         pcnt        <= pcnt_nx;
         serve_q     <= serve_q_nx;
         update_done <= done_nx;
      end
   end

   // Next-state logic: one pipeline stage per cycle after an accepted tick
   always_comb begin
      stage_nx    = stage;
      state_nx    = state;
      ball_x_nx   = ball_x;
      ball_y_nx   = ball_y;
      vx_nx       = vx;
      vy_nx       = vy;
      score_l_nx  = score_l;
      score_r_nx  = score_r;
      pcnt_nx     = pcnt;
      serve_q_nx  = serve_q;
      done_nx     = 1'b0;
      paddle_step = 1'b0;
      paddle_load = 1'b0;
      hit_l       = !vx && (ball_x <= HIT_XL) && overlap(ball_y, paddle_l_y);
      hit_r       =  vx && (ball_x >= HIT_XR) && overlap(ball_y, paddle_r_y);

      case (stage)
         STG_IDLE: begin
            if (frame_tick) begin
               stage_nx   = STG_PADDLE;
               serve_q_nx = serve;
            end
         end

         STG_PADDLE: begin
            paddle_step = (state != ST_OVER);
            stage_nx    = STG_BALL;
         end

         STG_BALL: begin
            if (state == ST_PLAY) begin
               if (vx)
                  ball_x_nx = (ball_x >= (BALL_X_MAX - BALL_STEP)) ? BALL_X_MAX : ball_x + BALL_STEP;
               else
                  ball_x_nx = (ball_x < BALL_STEP) ? '0 : ball_x - BALL_STEP;
               if (vy)
                  ball_y_nx = (ball_y >= (BALL_Y_MAX - BALL_STEP)) ? BALL_Y_MAX : ball_y + BALL_STEP;
               else
                  ball_y_nx = (ball_y < BALL_STEP) ? '0 : ball_y - BALL_STEP;
            end
            stage_nx = STG_RESOLVE;
         end

         STG_RESOLVE: begin
            stage_nx = STG_IDLE;
            done_nx  = 1'b1;
            case (state)
               ST_SERVE: begin
                  if (serve_q)
                     state_nx = ST_PLAY;
               end

               ST_PLAY: begin
                  // Vertical walls, resolved independently of the horizontal axis
                  if (!vy && (ball_y == '0)) begin
                     vy_nx = 1'b1;
                  end else if (ball_y >= BALL_Y_MAX) begin
                     ball_y_nx = BALL_Y_MAX;
                     vy_nx     = 1'b0;
                  end
                  // Paddle returns take priority over goal-line misses
                  if (hit_l) begin
                     ball_x_nx = HIT_XL;
                     vx_nx     = 1'b1;
                  end else if (hit_r) begin
                     ball_x_nx = HIT_XR;
                     vx_nx     = 1'b0;
                  end else if (ball_x == '0) begin
                     score_r_nx = sat_inc(score_r);
                     state_nx   = (sat_inc(score_r) == SCORE_MAX) ? ST_OVER : ST_POINT;
                     pcnt_nx    = '0;
                  end else if (ball_x >= BALL_X_MAX) begin
                     score_l_nx = sat_inc(score_l);
                     state_nx   = (sat_inc(score_l) == SCORE_MAX) ? ST_OVER : ST_POINT;
                     pcnt_nx    = '0;
                  end
               end

               ST_POINT: begin
                  if (pcnt == (POINT_FRAMES - 6'd1)) begin
                     pcnt_nx   = '0;
                     // The ball rests on the conceding player's goal line
                     vx_nx     = (ball_x >= BALL_X_MAX);
                     ball_x_nx = BALL_X0;
                     ball_y_nx = BALL_Y0;
                     state_nx  = ST_SERVE;
                  end else begin
                     pcnt_nx = pcnt + 6'd1;
                  end
               end

               ST_OVER: begin
                  if (serve_q) begin
                     score_l_nx  = '0;
                     score_r_nx  = '0;
                     ball_x_nx   = BALL_X0;
                     ball_y_nx   = BALL_Y0;
                     vx_nx       = 1'b1;
                     vy_nx       = 1'b1;
                     paddle_load = 1'b1;
                     state_nx    = ST_SERVE;
                  end
               end

               default: state_nx = ST_SERVE;
            endcase
         end

         default: stage_nx = STG_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pong_game_state.sv
// Directed bench for pong_game_state: follows one hand-traced match from reset,
// through paddle hits, wall bounces and misses, to game over and restart.
module tb_pong_game_state;

   logic       clk = 1'b0;
   logic       rst_n, ena, frame_tick, serve;
   logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
   logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
   logic [3:0] score_l, score_r;
   logic [1:0] game_state;
   logic       update_done;

   int checks   = 0;
   int failures = 0;

   pong_game_state dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .frame_tick  (frame_tick),
      .btn_l_up    (btn_l_up),
      .btn_l_dn    (btn_l_dn),
      .btn_r_up    (btn_r_up),
      .btn_r_dn    (btn_r_dn),
      .serve       (serve),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .paddle_l_y  (paddle_l_y),
      .paddle_r_y  (paddle_r_y),
      .score_l     (score_l),
      .score_r     (score_r),
      .game_state  (game_state),
      .update_done (update_done)
   );

   always #5 clk = ~clk;

   task automatic tick_frame();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_frames(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick_frame();
   endtask

   task automatic serve_frame();
      serve = 1'b1;
      tick_frame();
      serve = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; frame_tick = 1'b0; serve = 1'b0;
      btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL reset_ball got (%0d,%0d) exp (316,236)", ball_x, ball_y); end
      checks++; if ({paddle_l_y, paddle_r_y} !== {10'd208, 10'd208}) begin failures++; $display("FAIL reset_paddles got (%0d,%0d) exp (208,208)", paddle_l_y, paddle_r_y); end
      checks++; if ({score_l, score_r} !== 8'h00) begin failures++; $display("FAIL reset_scores got (%0d,%0d) exp (0,0)", score_l, score_r); end
      checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", game_state); end
      checks++; if (update_done !== 1'b0) begin failures++; $display("FAIL reset_update_done got %0b exp 0", update_done); end
   endtask

   // In SERVE: both buttons hold, left up to the top clamp, right down to the bottom clamp
   task automatic test_paddles();
      btn_l_up = 1'b1; btn_l_dn = 1'b1;
      run_frames(3);
      checks++; if (paddle_l_y !== 10'd208) begin failures++; $display("FAIL paddle_both_hold got %0d exp 208", paddle_l_y); end
      btn_l_dn = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         tick_frame();
         if (i == 51) begin checks++; if (paddle_l_y !== 10'd4) begin failures++; $display("FAIL paddle_up_51 got %0d exp 4", paddle_l_y); end end
         if (i == 52) begin checks++; if (paddle_l_y !== 10'd0) begin failures++; $display("FAIL paddle_up_52 got %0d exp 0", paddle_l_y); end end
      end
      checks++; if (paddle_l_y !== 10'd0) begin failures++; $display("FAIL paddle_up_clamp got %0d exp 0", paddle_l_y); end
      btn_l_up = 1'b0; btn_r_dn = 1'b1;
      run_frames(55);
      btn_r_dn = 1'b0;
      checks++; if (paddle_r_y !== 10'd416) begin failures++; $display("FAIL paddle_dn_clamp got %0d exp 416", paddle_r_y); end
      checks++; if ({game_state, ball_x, ball_y} !== {2'd0, 10'd316, 10'd236}) begin failures++; $display("FAIL serve_ball_frozen got st=%0d (%0d,%0d) exp st=0 (316,236)", game_state, ball_x, ball_y); end
   endtask

   task automatic test_serve();
      serve = 1'b1;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      serve = 1'b0;
      for (int j = 0; j < 5; j++) begin
         checks++; if (update_done !== (j == 3)) begin failures++; $display("FAIL update_done_cycle%0d got %0b exp %0b", j, update_done, (j == 3)); end
         @(negedge clk);
      end
      checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL serve_to_play got %0d exp 1", game_state); end
      checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL serve_frame_ball got (%0d,%0d) exp (316,236)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin failures++; $display("FAIL first_move got (%0d,%0d) exp (318,238)", ball_x, ball_y); end
   endtask

   // Play frame 1 done; bottom bounce at frame 118, right paddle (y=416) return at 146
   task automatic test_right_hit();
      run_frames(144);
      checks++; if ({ball_x, ball_y} !== {10'd606, 10'd418}) begin failures++; $display("FAIL pre_right_hit got (%0d,%0d) exp (606,418)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd608, 10'd416}) begin failures++; $display("FAIL right_hit got (%0d,%0d) exp (608,416)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd606, 10'd414}) begin failures++; $display("FAIL post_right_hit got (%0d,%0d) exp (606,414)", ball_x, ball_y); end
   endtask

   task automatic test_enable();
      ena = 1'b0; btn_l_dn = 1'b1; btn_r_up = 1'b1; serve = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick_frame();
         checks++;
         if ({ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r, game_state} !==
             {10'd606, 10'd414, 10'd0, 10'd416, 4'd0, 4'd0, 2'd1}) begin
            failures++;
            $display("FAIL ena_hold frame %0d got ball (%0d,%0d) pad (%0d,%0d) sc (%0d,%0d) st %0d exp (606,414) (0,416) (0,0) 1",
                     i, ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r, game_state);
         end
      end
      ena = 1'b1; btn_l_dn = 1'b0; btn_r_up = 1'b0; serve = 1'b0;
   endtask

   task automatic test_top_bounce();
      run_frames(206);
      checks++; if ({ball_x, ball_y} !== {10'd194, 10'd2}) begin failures++; $display("FAIL pre_top got (%0d,%0d) exp (194,2)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd192, 10'd0}) begin failures++; $display("FAIL top_bounce got (%0d,%0d) exp (192,0)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd190, 10'd2}) begin failures++; $display("FAIL post_top got (%0d,%0d) exp (190,2)", ball_x, ball_y); end
   endtask

   // Left paddle at 0 does not cover the ball: it reaches x=0 and the right player scores
   task automatic test_left_miss();
      run_frames(95);
      checks++; if ({ball_x, ball_y} !== {10'd0, 10'd192}) begin failures++; $display("FAIL left_miss_ball got (%0d,%0d) exp (0,192)", ball_x, ball_y); end
      checks++; if ({score_l, score_r} !== {4'd0, 4'd1}) begin failures++; $display("FAIL left_miss_score got (%0d,%0d) exp (0,1)", score_l, score_r); end
      checks++; if (game_state !== 2'd2) begin failures++; $display("FAIL left_miss_state got %0d exp 2", game_state); end
   endtask

   task automatic test_point_hold();
      for (int i = 1; i <= 60; i++) begin
         btn_r_up = (i <= 52);
         tick_frame();
         if (i == 59) begin checks++; if ({game_state, ball_x} !== {2'd2, 10'd0}) begin failures++; $display("FAIL point_hold_59 got st=%0d x=%0d exp st=2 x=0", game_state, ball_x); end end
      end
      btn_r_up = 1'b0;
      checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL point_to_serve got %0d exp 0", game_state); end
      checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL point_recentre got (%0d,%0d) exp (316,236)", ball_x, ball_y); end
      checks++; if (paddle_r_y !== 10'd208) begin failures++; $display("FAIL point_paddle_move got %0d exp 208", paddle_r_y); end
   endtask

   // Served toward the left (vy+): bottom at 118, left paddle (416) return at 146, right miss 304 frames later
   task automatic test_left_hit();
      btn_l_dn = 1'b1;
      run_frames(110);
      btn_l_dn = 1'b0;
      checks++; if (paddle_l_y !== 10'd416) begin failures++; $display("FAIL left_dn_clamp got %0d exp 416", paddle_l_y); end
      serve_frame();
      run_frames(145);
      checks++; if ({ball_x, ball_y} !== {10'd26, 10'd418}) begin failures++; $display("FAIL pre_left_hit got (%0d,%0d) exp (26,418)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd24, 10'd416}) begin failures++; $display("FAIL left_hit got (%0d,%0d) exp (24,416)", ball_x, ball_y); end
      tick_frame();
      checks++; if ({ball_x, ball_y} !== {10'd26, 10'd414}) begin failures++; $display("FAIL post_left_hit got (%0d,%0d) exp (26,414)", ball_x, ball_y); end
      run_frames(303);
      checks++; if ({ball_x, ball_y, score_l, game_state} !== {10'd632, 10'd192, 4'd1, 2'd2}) begin failures++; $display("FAIL right_miss got (%0d,%0d) score_l=%0d st=%0d exp (632,192) 1 2", ball_x, ball_y, score_l, game_state); end
      run_frames(60);
      checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL serve_after_right_miss got %0d exp 0", game_state); end
   endtask

   // Eight straight right misses take score_l from 1 to 9; the miss row alternates 392/80
   task automatic test_score_to_over();
      logic [9:0] exp_y;
      for (int k = 1; k <= 8; k++) begin
         exp_y = (k % 2 == 1) ? 10'd392 : 10'd80;
         serve_frame();
         run_frames(158);
         checks++;
         if ({ball_x, ball_y, score_l, score_r, game_state} !== {10'd632, exp_y, 4'(k + 1), 4'd1, (k == 8) ? 2'd3 : 2'd2}) begin
            failures++;
            $display("FAIL rally%0d got (%0d,%0d) sc (%0d,%0d) st %0d exp (632,%0d) (%0d,1) st %0d",
                     k, ball_x, ball_y, score_l, score_r, game_state, exp_y, k + 1, (k == 8) ? 3 : 2);
         end
         if (k < 8) begin
            run_frames(60);
            checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL rally%0d_serve got %0d exp 0", k, game_state); end
         end
      end
   endtask

   task automatic test_over();
      btn_l_up = 1'b1; btn_r_dn = 1'b1;
      run_frames(3);
      btn_l_up = 1'b0; btn_r_dn = 1'b0;
      checks++; if (game_state !== 2'd3) begin failures++; $display("FAIL over_hold got %0d exp 3", game_state); end
      checks++; if ({ball_x, ball_y, score_l, score_r} !== {10'd632, 10'd80, 4'd9, 4'd1}) begin failures++; $display("FAIL over_frozen got (%0d,%0d) sc (%0d,%0d) exp (632,80) (9,1)", ball_x, ball_y, score_l, score_r); end
      checks++; if ({paddle_l_y, paddle_r_y} !== {10'd416, 10'd208}) begin failures++; $display("FAIL over_paddles got (%0d,%0d) exp (416,208)", paddle_l_y, paddle_r_y); end
      serve_frame();
      checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL restart_state got %0d exp 0", game_state); end
      checks++; if ({score_l, score_r} !== 8'h00) begin failures++; $display("FAIL restart_scores got (%0d,%0d) exp (0,0)", score_l, score_r); end
      checks++; if ({ball_x, ball_y, paddle_l_y, paddle_r_y} !== {10'd316, 10'd236, 10'd208, 10'd208}) begin failures++; $display("FAIL restart_pos got (%0d,%0d) pad (%0d,%0d) exp (316,236) (208,208)", ball_x, ball_y, paddle_l_y, paddle_r_y); end
   endtask

   task automatic test_reset_mid_play();
      serve_frame();
      btn_l_up = 1'b1;
      run_frames(3);
      btn_l_up = 1'b0;
      checks++; if (paddle_l_y !== 10'd196) begin failures++; $display("FAIL play_paddle_move got %0d exp 196", paddle_l_y); end
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({ball_x, ball_y, paddle_l_y, paddle_r_y} !== {10'd316, 10'd236, 10'd208, 10'd208}) begin failures++; $display("FAIL midplay_reset_pos got (%0d,%0d) pad (%0d,%0d) exp (316,236) (208,208)", ball_x, ball_y, paddle_l_y, paddle_r_y); end
      checks++; if ({game_state, score_l, score_r} !== 10'd0) begin failures++; $display("FAIL midplay_reset_state got st=%0d sc (%0d,%0d) exp 0 (0,0)", game_state, score_l, score_r); end
      @(negedge clk) rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++; if (update_done !== 1'b0) begin failures++; $display("FAIL midplay_no_done cycle %0d got %0b exp 0", j, update_done); end
      end
      checks++; if ({game_state, ball_x, ball_y} !== {2'd0, 10'd316, 10'd236}) begin failures++; $display("FAIL post_reset_idle got st=%0d (%0d,%0d) exp 0 (316,236)", game_state, ball_x, ball_y); end
   endtask

   initial begin
      test_reset();
      test_paddles();
      test_serve();
      test_right_hit();
      test_enable();
      test_top_bounce();
      test_left_miss();
      test_point_hold();
      test_left_hit();
      test_score_to_over();
      test_over();
      test_reset_mid_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
